ysyx_23060240_lsu: RTL and testbench
====================================

Name: ysyx_23060240_lsu

Overview:
- Load/store unit directly upstream of the memory stage: accepts one memory op at a time from EXU, issues a word-aligned bus request, and returns formatted load data to WBU.
- Stores: byte-lane shifting and write-strobe generation. Loads: lane selection plus sign/zero extension.
- Multi-cycle, valid/ready on both sides. Replaces the combinational single-cycle memory read path for the pipelined core.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width (fixed at 32; strobe is 4 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EXU offers an op
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_rd_en  in  1  load op
- in_wr_en  in  1  store op
- in_rd_ctrl  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_wr_ctrl  in  2  00 SB, 01 SH, 10 SW
- in_addr  in  32  byte address
- in_wdata  in  32  store data, LSB-justified
- in_rd_idx  in  5  destination register tag
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  in_addr with [1:0] cleared
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte-lane enables
- mem_rsp_valid  in  1  response valid (read data or write ack)
- mem_rsp_rdata  in  32  raw bus word
- out_valid  out  1  result available to WBU
- out_ready  in  1  WBU accepts result
- out_rdata  out  32  extended load data; 0 for stores/no-ops
- out_rd_idx  out  5  tag passed through
- out_misalign  out  1  misaligned access; no bus transaction performed

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. mem_req_valid=0, out_valid=0, out_misalign=0, out_rdata=0, out_rd_idx=0, mem_req_* data fields=0, in_ready=1 in the first cycle after reset.
- FSM states and transitions:
  - IDLE -> REQ on in_valid && (rd_en || wr_en) && aligned.
  - IDLE -> DONE on in_valid && (misaligned || neither enable).
  - REQ: mem_req_valid=1, all request fields held stable until mem_req_ready; then -> WAIT.
  - WAIT: wait for mem_rsp_valid (always accepted; no rsp_ready) -> DONE, capturing formatted data.
  - DONE: out_valid=1, outputs held stable until out_ready; then -> IDLE.
- All request and response fields are registered at acceptance/capture. Operand inputs are ignored outside the IDLE accept cycle.
- Latency, with zero-wait bus, rsp one cycle after the request handshake, and out_ready=1:
  - accept at edge N
  - mem_req_valid during cycle N+1
  - rsp during N+2
  - out_valid during N+3
  - next accept at N+4
- Priority: wr_en and rd_en both set -> treated as store.
- Alignment rules:
  - LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=00.
  - Violation -> DONE with out_misalign=1, out_rdata=0, no mem_req_valid.
- Store formatting, off = addr[1:0]:
  - SB: wstrb = 0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<off; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata unchanged.
  - Reserved wr_ctrl 11 behaves as SW.
- Load formatting:
  - Byte = rdata >> (8*off), then [7:0]; LB sign-extends, LBU zero-extends.
  - Halfword = rdata >> (8*off), then [15:0]; LH sign-extends, LHU zero-extends.
  - LW passes the word through. Reserved rd_ctrl codes behave as LW.
  - Loads issue wstrb=0000.
- Store completion: mem_rsp_valid acts as the write ack; out_rdata=0.
- Spurious mem_rsp_valid outside WAIT is ignored.
- Reset mid-operation: abandons any outstanding bus request and returns to IDLE immediately. A late response arriving after reset is ignored.

Decomposition:
- Package ysyx_23060240_lsu_pkg holds:
  - rd_ctrl encodings LB/LH/LW/LBU/LHU
  - wr_ctrl encodings SB/SH/SW
  - FSM state enum IDLE/REQ/WAIT/DONE
- One combinational sub-module, ysyx_23060240_lsu_fmt: store lane/strobe generation, load extraction/extension, misalign detection. The FSM and registers stay in the top module.

Test Plan:
- LB at 0x80000003, bus word 0x80FF1234 -> out_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; mem_req_addr=0x80000000, wstrb=0000.
- LH at 0x80000002, word 0x8001_7FFF -> 0xFFFF8001; LHU at 0x80000000 -> 0x00007FFF.
- SB at 0x80000001 with wdata 0x000000AB -> wstrb=0010, wdata=0xABABABAB, wen=1; after ack, out_valid with out_rdata=0.
- LW at 0x80000002 -> out_misalign=1 in DONE, mem_req_valid never asserted, out_rdata=0.
- Backpressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles -> request and output fields stable throughout; in_ready low until the out handshake; in_valid during busy is not accepted.
- rst_n low during WAIT -> next cycle out_valid=0, mem_req_valid=0, in_ready=1; a later mem_rsp_valid produces no out_valid.

Source files
------------

// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared definitions for the load/store unit.
// This file holds the rd_ctrl and wr_ctrl encodings and the FSM state type.
// rd_ctrl and wr_ctrl are plain constants rather than enums because the
// reserved codes must still be decodable.
package ysyx_23060240_lsu_pkg;

    // Load width/sign selects (in_rd_ctrl).
    localparam logic [2:0] RD_LB  = 3'b000;
    localparam logic [2:0] RD_LH  = 3'b001;
    localparam logic [2:0] RD_LW  = 3'b010;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    // Store width selects (in_wr_ctrl). Code 2'b11 is reserved.
    localparam logic [1:0] WR_SB = 2'b00;
    localparam logic [1:0] WR_SH = 2'b01;
    localparam logic [1:0] WR_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/ysyx_23060240_lsu_if.sv
// Memory-side bus of the LSU: a request channel with valid/ready and a
// response channel that is valid-only.
//   master modport : LSU side. It drives the request and receives the response.
//   slave modport  : memory side.
interface ysyx_23060240_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_wen;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wstrb;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/ysyx_23060240_lsu_fmt.sv
// Combinational data formatting for the LSU.
//   acc_* : operands in the accept cycle. They produce store lanes, the
//           strobe and misalign detection.
//   rsp_* : registered load info plus the raw bus word. They produce the
//           extended load data.
module ysyx_23060240_lsu_fmt
    import ysyx_23060240_lsu_pkg::*;
(
    input  logic [1:0]  acc_off,
    input  logic [2:0]  acc_rd_ctrl,
    input  logic [1:0]  acc_wr_ctrl,
    input  logic        acc_is_store,
    input  logic [31:0] acc_wdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        misalign,
    input  logic [1:0]  rsp_off,
    input  logic [2:0]  rsp_rd_ctrl,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        misalign = 1'b0;
        if (acc_is_store) begin
            unique case (acc_wr_ctrl)
                WR_SB: begin
                    st_wstrb = 4'b0001 << acc_off;
                    st_wdata = {4{acc_wdata[7:0]}};
                end
                WR_SH: begin
                    st_wstrb = 4'b0011 << acc_off;
                    st_wdata = {2{acc_wdata[15:0]}};
                    misalign = acc_off[0];
                end
                default: begin  // SW and reserved code 2'b11
                    st_wstrb = 4'b1111;
                    st_wdata = acc_wdata;
                    misalign = |acc_off;
                end
            endcase
        end else begin
            unique case (acc_rd_ctrl)
                RD_LB, RD_LBU: misalign = 1'b0;
                RD_LH, RD_LHU: misalign = acc_off[0];
                default:       misalign = |acc_off;  // LW and reserved codes
            endcase
        end
    end

    assign shifted = rsp_rdata >> {rsp_off, 3'b000};

    always_comb begin
        ld_data = rsp_rdata;
        unique case (rsp_rd_ctrl)
            RD_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            RD_LBU:  ld_data = {24'h0, shifted[7:0]};
            RD_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            RD_LHU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = rsp_rdata;
        endcase
    end
endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Multi-cycle load/store unit between EXU and memory.
//   clk, rst_n : clock and synchronous active-low reset.
//   in_*       : op from EXU. in_valid/in_ready handshake; the op is accepted only in IDLE.
//   mem        : word-aligned bus request with a valid-only response.
//   out_*      : formatted result to WBU. out_valid/out_ready handshake.
// Misaligned ops and ops with neither enable set go straight to DONE
// without a bus transaction.
module ysyx_23060240_lsu
    import ysyx_23060240_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rd_en,
    input  logic              in_wr_en,
    input  logic [2:0]        in_rd_ctrl,
    input  logic [1:0]        in_wr_ctrl,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd_idx,
    ysyx_23060240_lsu_if.master mem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [4:0]        out_rd_idx,
    output logic              out_misalign
);
    lsu_state_e        state, state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [2:0]        rd_ctrl_q;
    logic [1:0]        off_q;

    logic        any_op, accept, go_req, acc_misalign;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    ysyx_23060240_lsu_fmt u_fmt (
        .acc_off      (in_addr[1:0]),
        .acc_rd_ctrl  (in_rd_ctrl),
        .acc_wr_ctrl  (in_wr_ctrl),
        .acc_is_store (in_wr_en),
        .acc_wdata    (in_wdata),
        .st_wdata     (st_wdata),
        .st_wstrb     (st_wstrb),
        .misalign     (acc_misalign),
        .rsp_off      (off_q),
        .rsp_rd_ctrl  (rd_ctrl_q),
        .rsp_rdata    (mem.mem_rsp_rdata),
        .ld_data      (ld_data)
    );

    assign any_op = in_rd_en | in_wr_en;
    assign accept = (state == IDLE) && in_valid;
    assign go_req = accept && any_op && !acc_misalign;

    assign in_ready          = (state == IDLE);
    assign out_valid         = (state == DONE);
    assign mem.mem_req_valid = (state == REQ);
    assign mem.mem_req_addr  = req_addr;
    assign mem.mem_req_wen   = req_wen;
    assign mem.mem_req_wdata = req_wdata;
    assign mem.mem_req_wstrb = req_wstrb;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = go_req ? REQ : DONE;
            REQ:  if (mem.mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem.mem_rsp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_wen      <= 1'b0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            rd_ctrl_q    <= '0;
            off_q        <= '0;
            out_rdata    <= '0;
            out_rd_idx   <= '0;
            out_misalign <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_rd_idx   <= in_rd_idx;
                out_rdata    <= '0;
                out_misalign <= any_op & acc_misalign;
            end
            if (go_req) begin
                req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                req_wen   <= in_wr_en;  // a store wins when both enables are set
                req_wdata <= st_wdata;
                req_wstrb <= st_wstrb;
                rd_ctrl_q <= in_rd_ctrl;
                off_q     <= in_addr[1:0];
            end
            if (state == WAIT && mem.mem_rsp_valid)
                out_rdata <= req_wen ? '0 : ld_data;
        end
    end
endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Self-checking bench for ysyx_23060240_lsu.
// It runs directed ops and then random ops. Expected values come from the
// byte-arithmetic reference functions below.
module tb_ysyx_23060240_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_rd_en, in_wr_en;
    logic [2:0]  in_rd_ctrl;
    logic [1:0]  in_wr_ctrl;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd_idx;
    logic        out_valid, out_ready, out_misalign;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd_idx;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ysyx_23060240_lsu_if bus ();

    ysyx_23060240_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd_en     (in_rd_en),
        .in_wr_en     (in_wr_en),
        .in_rd_ctrl   (in_rd_ctrl),
        .in_wr_ctrl   (in_wr_ctrl),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd_idx    (in_rd_idx),
        .mem          (bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_rd_idx   (out_rd_idx),
        .out_misalign (out_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes. Reserved codes behave as a full word.
    function automatic int unsigned rd_size(input logic [2:0] c);
        if (c == 3'b000 || c == 3'b100) return 1;
        if (c == 3'b001 || c == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int unsigned wr_size(input logic [1:0] c);
        if (c == 2'b00) return 1;
        if (c == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input int unsigned off,
                                               input logic [31:0] word);
        int unsigned sz;
        logic [31:0] v;
        sz = rd_size(c);
        if (sz == 4) return word;
        v = (word >> (8 * off)) % (32'd1 << (8 * sz));
        if (c[2] == 1'b0 && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    function automatic logic [31:0] model_wstrb(input logic [1:0] c, input int unsigned off);
        int unsigned sz;
        sz = wr_size(c);
        if (sz == 4) return 32'hF;
        return ((32'd1 << sz) - 1) << off;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] c, input logic [31:0] d);
        int unsigned sz;
        sz = wr_size(c);
        if (sz == 1) return (d % 256) * 32'h01010101;
        if (sz == 2) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    task automatic scramble_inputs();
        in_rd_en   = 1'($urandom);
        in_wr_en   = 1'($urandom);
        in_rd_ctrl = 3'($urandom);
        in_wr_ctrl = 2'($urandom);
        in_addr    = $urandom;
        in_wdata   = $urandom;
        in_rd_idx  = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] rc, input logic [1:0] wc,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] idx, input logic [31:0] word,
                          input int req_stall, input int out_stall);
        logic        op, mis;
        int unsigned sz, off;
        logic [31:0] exp_data, exp_addr, exp_strb, exp_wdata;
        op  = rd | wr;
        off = addr % 4;
        sz  = wr ? wr_size(wc) : rd_size(rc);
        mis = op && (addr % sz != 0);
        exp_data  = (!op || mis || wr) ? 32'h0 : model_load(rc, off, word);
        exp_addr  = addr - off;
        exp_strb  = wr ? model_wstrb(wc, off) : 32'h0;
        exp_wdata = model_wdata(wc, wd);

        @(negedge clk);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_rd_en = rd; in_wr_en = wr; in_rd_ctrl = rc;
        in_wr_ctrl = wc; in_addr = addr; in_wdata = wd; in_rd_idx = idx;
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        if (op && !mis) begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, ".req_valid"}, 32'(bus.mem_req_valid), 32'd1);
                check({tag, ".req_addr"}, bus.mem_req_addr, exp_addr);
                check({tag, ".req_wen"}, 32'(bus.mem_req_wen), 32'(wr));
                check({tag, ".req_wstrb"}, 32'(bus.mem_req_wstrb), exp_strb);
                if (wr) check({tag, ".req_wdata"}, bus.mem_req_wdata, exp_wdata);
                if (i < req_stall) begin
                    in_valid = 1'b1;                       // must not be accepted
                    bus.mem_rsp_valid = 1'($urandom);      // spurious, must be ignored
                    bus.mem_rsp_rdata = $urandom;
                    @(negedge clk);
                    check({tag, ".in_ready_req"}, 32'(in_ready), 32'd0);
                end
            end
            in_valid = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check({tag, ".wait_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
            check({tag, ".wait_out_valid"}, 32'(out_valid), 32'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = word;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = $urandom;
        end else begin
            check({tag, ".no_req"}, 32'(bus.mem_req_valid), 32'd0);
        end
        for (int i = 0; i <= out_stall; i++) begin
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".out_rdata"}, out_rdata, exp_data);
            check({tag, ".out_rd_idx"}, 32'(out_rd_idx), 32'(idx));
            check({tag, ".out_misalign"}, 32'(out_misalign), 32'(mis));
            check({tag, ".done_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
            if (i < out_stall) begin
                in_valid = 1'b1;
                bus.mem_rsp_valid = 1'($urandom);
                bus.mem_rsp_rdata = $urandom;
                @(negedge clk);
                check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_released"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble_inputs();
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.misalign", 32'(out_misalign), 32'd0);
        check("rst.rdata", out_rdata, 32'd0);
        check("rst.rd_idx", 32'(out_rd_idx), 32'd0);
        check("rst.req_addr", bus.mem_req_addr, 32'd0);
        check("rst.req_wdata", bus.mem_req_wdata, 32'd0);
        check("rst.req_wstrb", 32'(bus.mem_req_wstrb), 32'd0);
        check("rst.req_wen", 32'(bus.mem_req_wen), 32'd0);
        rst_n = 1'b1;

        // Spurious response while idle.
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("spur.out_valid", 32'(out_valid), 32'd0);

        run_op("lb",   1, 0, 3'b000, 2'b00, 32'h80000003, 32'h0,  5'd1, 32'h80FF1234, 0, 0);
        run_op("lbu",  1, 0, 3'b100, 2'b00, 32'h80000003, 32'h0,  5'd2, 32'h80FF1234, 0, 0);
        run_op("lh",   1, 0, 3'b001, 2'b00, 32'h80000002, 32'h0,  5'd3, 32'h80017FFF, 0, 0);
        run_op("lhu",  1, 0, 3'b101, 2'b00, 32'h80000000, 32'h0,  5'd4, 32'h80017FFF, 0, 0);
        run_op("sb",   0, 1, 3'b000, 2'b00, 32'h80000001, 32'hAB, 5'd5, 32'hDEADBEEF, 0, 0);
        run_op("lwmis",1, 0, 3'b010, 2'b00, 32'h80000002, 32'h0,  5'd6, 32'h0, 0, 0);
        run_op("shbp", 0, 1, 3'b000, 2'b01, 32'h80000002, 32'h1234CAFE, 5'd7, 32'h0, 3, 2);
        run_op("lwbp", 1, 0, 3'b010, 2'b00, 32'h80000004, 32'h0,  5'd8, 32'h13579BDF, 3, 2);
        run_op("noop", 0, 0, 3'b010, 2'b10, 32'h80000000, 32'h0,  5'd9, 32'h0, 0, 1);
        run_op("both", 1, 1, 3'b010, 2'b10, 32'h80000008, 32'hA5A55A5A, 5'd10, 32'hFFFFFFFF, 0, 0);
        run_op("sw11", 0, 1, 3'b000, 2'b11, 32'h80000006, 32'h1, 5'd11, 32'h0, 0, 0);
        run_op("shmis",0, 1, 3'b000, 2'b01, 32'h80000003, 32'h1, 5'd12, 32'h0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op("rand", 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
                   $urandom, $urandom, 5'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for a response, then a late response.
        @(negedge clk);
        in_valid = 1'b1; in_rd_en = 1'b1; in_wr_en = 1'b0; in_rd_ctrl = 3'b010;
        in_addr = 32'h80000010; in_rd_idx = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstw.req_valid", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw.out_valid", 32'(out_valid), 32'd0);
        check("rstw.req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rstw.in_ready", 32'(in_ready), 32'd1);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h12345678;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("rstw.late_out_valid", 32'(out_valid), 32'd0);
        check("rstw.late_in_ready", 32'(in_ready), 32'd1);
        check("rstw.late_rdata", out_rdata, 32'd0);

        run_op("post", 1, 0, 3'b000, 2'b00, 32'h80000002, 32'h0, 5'd30, 32'h00C30000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
